uart_tx: RTL and testbench

UART serial transmitter that serialises one parallel byte per request onto the `tx` line as an asynchronous frame: start bit, LSB-first data, optional parity, stop bit(s). Bit timing comes from the single-cycle `s_tick` oversampling strobe produced by `baud_gen`, at 16 ticks per bit. It sits between the host-side write path (FIFO or register interface) and the serial pin, and is the transmit counterpart of the UART receive path.

---
 rtl/uart_tx.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx - asynchronous serial transmitter
//
// Sends one byte per accepted request as a UART frame. The frame is a start
// bit, DBIT data bits sent LSB first, an optional parity bit and a stop
// period. Bit timing comes from a 16x oversampling strobe (s_tick). Each
// start, data and parity bit lasts 16 strobes. The stop period lasts
// SB_TICK strobes.
//
// Parameters:
//   DBIT     data bits per frame (5..8)
//   SB_TICK  stop period in strobes (16, 24 or 32)
//   PARITY   0 = none, 1 = odd, 2 = even
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   s_tick        in   16x baud strobe, one clk cycle wide
//   tx_start      in   transmit request, sampled only while idle
//   din[7:0]      in   byte to send, bits [DBIT-1:0] used, captured on accept
//   tx_done_tick  out  one-cycle pulse after the last stop strobe
//   tx_busy       out  high while a frame is in progress
//   tx            out  registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       tx_busy,
  output logic       tx
);

  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] DATA_LAST = 3'(DBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        s_cnt_q, s_cnt_d;
  logic [2:0]        n_cnt_q, n_cnt_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic              p_q, p_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // The accumulator holds the XOR of the data bits sent so far. Even parity
  // sends it unchanged. Odd parity sends its complement.
  function automatic logic parity_out(input logic acc);
    if (PARITY == 2) begin
      return acc;
    end else begin
      return ~acc;
    end
  endfunction

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_cnt_q <= 5'd0;
      n_cnt_q <= 3'd0;
      b_q     <= '0;
      p_q     <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic. Counters only move on a strobe, so between strobes
  // everything holds.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    p_d     = p_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A strobe in the accept cycle is not counted, because IDLE ignores s_tick.
        if (tx_start) begin
          b_d     = din[DBIT-1:0];
          s_cnt_d = 5'd0;
          p_d     = 1'b0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = 5'd0;
            n_cnt_d = 3'd0;
            state_d = ST_DATA;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end else begin
          state_d = ST_START;
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = 5'd0;
            b_d     = b_q >> 1;
            p_d     = p_q ^ b_q[0];
            if (n_cnt_q == DATA_LAST) begin
              state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
            end else begin
              n_cnt_d = n_cnt_q + 3'd1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_PAR: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = 5'd0;
            state_d = ST_STOP;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end else begin
          state_d = ST_PAR;
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            s_cnt_d = 5'd0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end

      default: begin
        // Unreachable encodings fall back to idle, and the line returns high.
        state_d = ST_IDLE;
        s_cnt_d = 5'd0;
        n_cnt_d = 3'd0;
      end
    endcase
  end

  // The line level is derived from the next state. This way tx changes on the
  // same edge that changes the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_IDLE:  tx_d = 1'b1;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = b_d[0];
      ST_PAR:   tx_d = parity_out(p_d);
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx - self-checking bench for uart_tx
//
// Four transmitters with different configurations share one clock, strobe
// and request path:
//   dut0  DBIT=8, no parity, 1 stop bit
//   dut1  DBIT=8, even parity, 1 stop bit
//   dut2  DBIT=8, odd parity, 1 stop bit
//   dut3  DBIT=7, no parity, 2 stop bits
// The expected line level for every strobe is computed from the frame format
// (start, LSB-first data, parity, stop) using plain arithmetic.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic [3:0] tx_w;
  logic [3:0] done_w;
  logic [3:0] busy_w;

  int n_checks;
  int n_fail;
  int last_done_cyc [4];

  int cfg_dbit [4] = '{8, 8, 8, 7};
  int cfg_par  [4] = '{0, 2, 1, 0};
  int cfg_sb   [4] = '{16, 16, 16, 32};

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_done_tick(done_w[0]), .tx_busy(busy_w[0]), .tx(tx_w[0]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_done_tick(done_w[1]), .tx_busy(busy_w[1]), .tx(tx_w[1]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) dut2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_done_tick(done_w[2]), .tx_busy(busy_w[2]), .tx(tx_w[2]));
  uart_tx #(.DBIT(7), .SB_TICK(32), .PARITY(0)) dut3 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_done_tick(done_w[3]), .tx_busy(busy_w[3]), .tx(tx_w[3]));

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running strobe, one clk wide, every 4 clk.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  // Length of one frame in strobes.
  function automatic int frame_ticks(input int idx);
    return 16 * (1 + cfg_dbit[idx] + ((cfg_par[idx] != 0) ? 1 : 0)) + cfg_sb[idx];
  endfunction

  // Expected line level for bit slot pos of a frame.
  // Slot 0 is the start bit, slots 1..DBIT are data bits, then the parity
  // bit if enabled, and the stop bits after that.
  function automatic logic exp_bit(input int idx, input logic [7:0] d, input int pos);
    int dbit;
    int dv;
    int ones;
    dbit = cfg_dbit[idx];
    dv   = int'(d) & ((1 << dbit) - 1);
    if (pos == 0) return 1'b0;
    if (pos <= dbit) return 1'((dv >> (pos - 1)) & 1);
    if (cfg_par[idx] != 0 && pos == dbit + 1) begin
      ones = $countones(dv);
      if (cfg_par[idx] == 2) return 1'(ones % 2);
      else return 1'((ones + 1) % 2);
    end
    return 1'b1;
  endfunction

  // Sends one byte and checks every strobe on all four transmitters until
  // each one has completed its frame. If glitch_k > 0, tx_start is pulsed
  // for one cycle with a different byte once dut0 has seen glitch_k strobes.
  // That pulse must be ignored.
  task automatic run_frame(input logic [7:0] d, input int glitch_k, input string name);
    int k [4];
    bit fin [4];
    int cyc;
    int g;
    bit all_fin;
    for (int i = 0; i < 4; i++) begin
      k[i] = 0;
      fin[i] = 1'b0;
      last_done_cyc[i] = -1;
    end
    g = 0;
    @(negedge clk);
    din = d;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_w[i] !== 1'b0 || busy_w[i] !== 1'b1 || done_w[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s accept dut%0d: tx=%b busy=%b done=%b, expected tx=0 busy=1 done=0",
                 name, i, tx_w[i], busy_w[i], done_w[i]);
      end
    end
    cyc = 0;
    all_fin = 1'b0;
    while (!all_fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (fin[i]) begin
          n_checks++;
          if (done_w[i] !== 1'b0 || busy_w[i] !== 1'b0 || tx_w[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after_done dut%0d: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0",
                     name, i, tx_w[i], busy_w[i], done_w[i]);
          end
        end else if (k[i] == frame_ticks(i)) begin
          n_checks++;
          if (done_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || tx_w[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done dut%0d: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=1",
                     name, i, tx_w[i], busy_w[i], done_w[i]);
          end
          fin[i] = 1'b1;
          last_done_cyc[i] = cyc;
        end else begin
          n_checks++;
          if (done_w[i] !== 1'b0 || busy_w[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_frame dut%0d k=%0d: busy=%b done=%b, expected busy=1 done=0",
                     name, i, k[i], busy_w[i], done_w[i]);
          end
          if (s_tick) begin
            k[i]++;
            n_checks++;
            if (tx_w[i] !== exp_bit(i, d, (k[i] - 1) / 16)) begin
              n_fail++;
              $display("FAIL %s bit dut%0d strobe=%0d: tx=%b expected %b",
                       name, i, k[i], tx_w[i], exp_bit(i, d, (k[i] - 1) / 16));
            end
          end
        end
      end
      if (g == 1) begin
        tx_start = 1'b0;
        g = 2;
      end else if (g == 0 && glitch_k > 0 && k[0] == glitch_k) begin
        tx_start = 1'b1;
        din = ~d;
        g = 1;
      end
      all_fin = fin[0] && fin[1] && fin[2] && fin[3];
    end
    n_checks++;
    if (!all_fin) begin
      n_fail++;
      $display("FAIL %s timeout: finished=%b%b%b%b, expected 1111", name, fin[3], fin[2], fin[1], fin[0]);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (done_w[i] !== 1'b0 || busy_w[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s trailing dut%0d: busy=%b done=%b, expected 0 0", name, i, busy_w[i], done_w[i]);
      end
    end
  endtask

  // Waits, with a bound, until all four transmitters are idle.
  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy_w !== 4'b0000 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (busy_w !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s wait_idle: busy=%b, expected 0000", name, busy_w);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_start = 1'b1;
    din = 8'hA5;
    repeat (20) begin
      @(negedge clk);
      n_checks++;
      if (tx_w !== 4'b1111 || busy_w !== 4'b0000 || done_w !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset: tx=%b busy=%b done=%b, expected 1111 0000 0000", tx_w, busy_w, done_w);
      end
    end
    tx_start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_w !== 4'b1111 || busy_w !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: tx=%b busy=%b, expected 1111 0000", tx_w, busy_w);
    end
  endtask

  task automatic test_default();
    run_frame(8'hA5, 0, "default_a5");
    // The 160th strobe is consumed 637..640 clk after acceptance, depending
    // on the strobe phase. The done pulse is then seen one negedge later.
    n_checks++;
    if (last_done_cyc[0] < 638 || last_done_cyc[0] > 641) begin
      n_fail++;
      $display("FAIL default_latency: done at negedge %0d, expected 638..641", last_done_cyc[0]);
    end
  endtask

  task automatic test_parity();
    run_frame(8'h07, 0, "parity_07");
    run_frame(8'h03, 0, "parity_03");
  endtask

  task automatic test_dbit7();
    run_frame(8'hFF, 0, "dbit7_ff");
    run_frame(8'h7F, 0, "dbit7_7f");
  endtask

  task automatic test_ignore();
    run_frame(8'($urandom), 40, "ignore_midframe");
  endtask

  task automatic test_back_to_back();
    logic [7:0] dq [2];
    int k;
    int fr;
    int cyc;
    dq[0] = 8'h55;
    dq[1] = 8'hAA;
    @(negedge clk);
    din = dq[0];
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    din = dq[1];
    k = 0;
    fr = 0;
    cyc = 0;
    while (fr < 2 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (k == frame_ticks(0)) begin
        n_checks++;
        if (done_w[0] !== 1'b1 || tx_w[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b done frame%0d: tx=%b done=%b, expected tx=1 done=1", fr, tx_w[0], done_w[0]);
        end
        fr++;
        k = 0;
        if (fr == 2) begin
          tx_start = 1'b0;
        end else begin
          @(posedge clk);
          #1;
          n_checks++;
          if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b restart: tx=%b busy=%b, expected tx=0 busy=1", tx_w[0], busy_w[0]);
          end
        end
      end else begin
        n_checks++;
        if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b in_frame%0d k=%0d: busy=%b done=%b, expected 1 0", fr, k, busy_w[0], done_w[0]);
        end
        if (s_tick) begin
          k++;
          n_checks++;
          if (tx_w[0] !== exp_bit(0, dq[fr], (k - 1) / 16)) begin
            n_fail++;
            $display("FAIL b2b bit frame%0d strobe=%0d: tx=%b expected %b",
                     fr, k, tx_w[0], exp_bit(0, dq[fr], (k - 1) / 16));
          end
        end
      end
    end
    tx_start = 1'b0;
    n_checks++;
    if (fr != 2) begin
      n_fail++;
      $display("FAIL b2b timeout: frames=%0d, expected 2", fr);
    end
    @(negedge clk);
    n_checks++;
    if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b no_third: busy=%b done=%b, expected 0 0", busy_w[0], done_w[0]);
    end
    wait_idle("b2b");
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    int k;
    int cyc;
    d = 8'($urandom);
    @(negedge clk);
    din = d;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    k = 0;
    cyc = 0;
    // Strobe 72 falls in slot 4, which is data bit 3.
    while (k < 72 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (s_tick) k++;
    end
    n_checks++;
    if (tx_w[0] !== exp_bit(0, d, 4)) begin
      n_fail++;
      $display("FAIL midreset pre bit3: tx=%b expected %b", tx_w[0], exp_bit(0, d, 4));
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (tx_w !== 4'b1111 || busy_w !== 4'b0000 || done_w !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset async: tx=%b busy=%b done=%b, expected 1111 0000 0000", tx_w, busy_w, done_w);
    end
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (done_w !== 4'b0000 || tx_w !== 4'b1111) begin
        n_fail++;
        $display("FAIL midreset hold: tx=%b done=%b, expected 1111 0000", tx_w, done_w);
      end
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(8'($urandom), 0, "midreset_next");
  endtask

  task automatic test_random();
    for (int n = 0; n < 5; n++) begin
      run_frame(8'($urandom_range(255, 0)), 0, "random");
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    tx_start = 1'b0;
    din = 8'h00;
    test_reset();
    test_default();
    test_parity();
    test_dbit7();
    test_ignore();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
